// File: rtl/layer_compositor.sv
// Priority pixel compositor: picks the lowest-index opaque, enabled layer once per pixel slot.
// Optional blink support is built when BLINK_EN is defined.
module layer_compositor #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 3,
  parameter int CLK_DIV      = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 visible,
  input  logic                                 frame_start,
  input  logic [NUM_LAYERS*(COLOR_W+1)-1:0]    in_layers,
  input  logic [COLOR_W-1:0]                   bg_color,
  input  logic                                 cfg_valid,
  input  logic [NUM_LAYERS-1:0]                cfg_mask,
  input  logic [NUM_LAYERS-1:0]                cfg_blink,
  output logic                                 cfg_ready,
  output logic [COLOR_W-1:0]                   oRGB,
  output logic                                 pix_strobe,
  output logic                                 hit_any,
  output logic [$clog2(NUM_LAYERS)-1:0]        hit_idx
);
  localparam int IDX_W = $clog2(NUM_LAYERS);
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW    = COLOR_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [PH_W-1:0]       r_phase;
  logic [0:0]            r_state;
  logic [NUM_LAYERS-1:0] r_active;
  logic [NUM_LAYERS-1:0] r_pending;
  logic [NUM_LAYERS-1:0] w_blink_ok;
  logic [NUM_LAYERS-1:0] w_elig;
  logic [IDX_W-1:0]      w_win_idx;
  logic [COLOR_W-1:0]    w_win_col;
  logic                  w_hit;
  logic                  w_slot;

  generate
    if (CLK_DIV > 1) begin : g_phase
      always_ff @(posedge clock) begin
        if (reset)
          r_phase <= '0;
        else if (r_phase == PH_W'(CLK_DIV - 1))
          r_phase <= '0;
        else
          r_phase <= r_phase + 1'b1;
      end
    end else begin : g_no_phase
      assign r_phase = '0;
    end
  endgenerate

  assign w_slot    = visible & (r_phase == '0);
  assign cfg_ready = (r_state == S_IDLE);

  // Config handshake: a mask accepted in IDLE waits in PEND for the next frame boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_active  <= '1;
      r_pending <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (cfg_valid) begin
          r_pending <= cfg_mask;
          r_state   <= S_PEND;
        end
        S_PEND: if (frame_start) begin
          r_active <= r_pending;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0]       r_fcnt;
  logic                  r_blink_on;
  logic [NUM_LAYERS-1:0] r_blink_mask;
  logic [NUM_LAYERS-1:0] r_pend_blink;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fcnt       <= '0;
      r_blink_on   <= 1'b1;
      r_blink_mask <= '0;
      r_pend_blink <= '0;
    end else begin
      if (r_state == S_IDLE && cfg_valid)
        r_pend_blink <= cfg_blink;
      if (r_state == S_PEND && frame_start)
        r_blink_mask <= r_pend_blink;
      if (frame_start) begin
        if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
          r_fcnt     <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  assign w_blink_ok = ~(r_blink_mask & {NUM_LAYERS{~r_blink_on}});
`else
  logic w_unused_blink;
  assign w_unused_blink = ^cfg_blink;
  assign w_blink_ok     = '1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_elig
      assign w_elig[gi] = in_layers[gi*LW + COLOR_W] & r_active[gi] & w_blink_ok[gi];
    end
  endgenerate

  // Scan from the lowest priority upward so the lowest eligible index is the last write.
  always_comb begin
    w_hit     = 1'b0;
    w_win_idx = '0;
    w_win_col = bg_color;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_hit     = 1'b1;
        w_win_idx = IDX_W'(i);
        w_win_col = in_layers[i*LW +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !w_slot) begin
      oRGB    <= '0;
      hit_any <= 1'b0;
      hit_idx <= '0;
    end else begin
      oRGB    <= w_win_col;
      hit_any <= w_hit;
      hit_idx <= w_win_idx;
    end
    pix_strobe <= !reset && w_slot;
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: constant vector table, directed handshake
// sequences and randomized traffic against a frame/slot-level reference model.
module tb_layer_compositor;
  localparam int N   = 4;
  localparam int CW  = 3;
  localparam int DIV = 2;
  localparam int BF  = 2;
  localparam int LW  = CW + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              visible;
  logic              frame_start;
  logic [N*LW-1:0]   in_layers;
  logic [CW-1:0]     bg_color;
  logic              cfg_valid;
  logic [N-1:0]      cfg_mask;
  logic [N-1:0]      cfg_blink;
  logic              cfg_ready;
  logic [CW-1:0]     oRGB;
  logic              pix_strobe;
  logic              hit_any;
  logic [1:0]        hit_idx;

  layer_compositor #(.NUM_LAYERS(N), .COLOR_W(CW), .CLK_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset(reset), .visible(visible), .frame_start(frame_start),
    .in_layers(in_layers), .bg_color(bg_color), .cfg_valid(cfg_valid),
    .cfg_mask(cfg_mask), .cfg_blink(cfg_blink), .cfg_ready(cfg_ready),
    .oRGB(oRGB), .pix_strobe(pix_strobe), .hit_any(hit_any), .hit_idx(hit_idx)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_phase;
  bit [N-1:0] m_active, m_pend_mask, m_blink_mask, m_pend_blink;
  bit         m_pend;
  int         m_fcnt;
  bit         m_blink_on;

  typedef struct {
    logic            vis;
    logic [N*LW-1:0] layers;
    logic [CW-1:0]   bg;
    logic [CW-1:0]   exp_rgb;
    logic            exp_hit;
    logic [1:0]      exp_idx;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*LW-1:0] lay(input int idx, input bit op, input int col,
                                          input logic [N*LW-1:0] base);
    logic [N*LW-1:0] v;
    logic [LW-1:0]   f;
    v = base;
    f = {op, 3'(col)};
    v[idx*LW +: LW] = f;
    return v;
  endfunction

  function automatic void model_reset();
    m_phase      = 0;
    m_active     = '1;
    m_pend_mask  = '0;
    m_pend       = 1'b0;
    m_blink_mask = '0;
    m_pend_blink = '0;
    m_fcnt       = 0;
    m_blink_on   = 1'b1;
  endfunction

  // One clock: predict from current inputs, advance model, then compare after the edge.
  task automatic step(input string tag);
    int  e_rgb, e_hit, e_idx, e_str;
    bit  blink_build;
    bit  elig;
`ifdef BLINK_EN
    blink_build = 1'b1;
`else
    blink_build = 1'b0;
`endif
    chk({tag, ".cfg_ready"}, int'(cfg_ready), int'(!m_pend));
    e_rgb = 0; e_hit = 0; e_idx = 0;
    e_str = (visible && m_phase == 0) ? 1 : 0;
    if (e_str == 1) begin
      e_rgb = int'(bg_color);
      for (int i = 0; i < N; i++) begin
        elig = in_layers[i*LW + CW] && m_active[i] &&
               !(blink_build && !m_blink_on && m_blink_mask[i]);
        if (elig && e_hit == 0) begin
          e_hit = 1;
          e_idx = i;
          e_rgb = int'(in_layers[i*LW +: CW]);
        end
      end
    end
    if (!m_pend && cfg_valid) begin
      m_pend       = 1'b1;
      m_pend_mask  = cfg_mask;
      m_pend_blink = cfg_blink;
    end else if (m_pend && frame_start) begin
      m_pend       = 1'b0;
      m_active     = m_pend_mask;
      m_blink_mask = m_pend_blink;
    end
    if (frame_start) begin
      if (m_fcnt == BF - 1) begin
        m_fcnt     = 0;
        m_blink_on = !m_blink_on;
      end else begin
        m_fcnt++;
      end
    end
    m_phase = (m_phase + 1) % DIV;
    @(posedge clock); #1;
    chk({tag, ".oRGB"},       int'(oRGB),       e_rgb);
    chk({tag, ".hit_any"},    int'(hit_any),    e_hit);
    chk({tag, ".hit_idx"},    int'(hit_idx),    e_idx);
    chk({tag, ".pix_strobe"}, int'(pix_strobe), e_str);
  endtask

  // Advance to and through the next pixel slot, then check its output by hand value.
  task automatic slot(input string tag, input int rgb, input int hit, input int idx);
    while (m_phase != 0) step({tag, ".align"});
    step(tag);
    chk({tag, ".hand_rgb"}, int'(oRGB), rgb);
    chk({tag, ".hand_hit"}, int'(hit_any), hit);
    chk({tag, ".hand_idx"}, int'(hit_idx), idx);
    $display("slot %s: oRGB=%0d hit_any=%0d hit_idx=%0d", tag, oRGB, hit_any, hit_idx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    chk("reset.oRGB", int'(oRGB), 0);
    chk("reset.pix_strobe", int'(pix_strobe), 0);
    chk("reset.hit_any", int'(hit_any), 0);
    chk("reset.hit_idx", int'(hit_idx), 0);
    chk("reset.cfg_ready", int'(cfg_ready), 1);
    model_reset();
    reset = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [N*LW-1:0] z;
    z = '0;
    vecs[0] = '{1'b1, lay(0, 1, 5, z), 3'd2, 3'd5, 1'b1, 2'd0};
    vecs[1] = '{1'b1, lay(2, 1, 6, lay(1, 1, 3, z)), 3'd2, 3'd3, 1'b1, 2'd1};
    vecs[2] = '{1'b1, z, 3'd7, 3'd7, 1'b0, 2'd0};
    vecs[3] = '{1'b0, lay(0, 1, 5, z), 3'd7, 3'd0, 1'b0, 2'd0};
    vecs[4] = '{1'b1, lay(3, 1, 4, lay(2, 0, 6, z)), 3'd1, 3'd4, 1'b1, 2'd3};
    vecs[5] = '{1'b1, lay(3, 1, 4, lay(2, 1, 3, lay(1, 1, 2, lay(0, 1, 1, z)))),
                3'd0, 3'd1, 1'b1, 2'd0};

    visible = 1'b1; frame_start = 1'b0; in_layers = '0; bg_color = '0;
    cfg_valid = 1'b0; cfg_mask = '0; cfg_blink = '0;
    model_reset();

    // Test 1: after reset, alternating slot / gap with layer 0 colour 5
    in_layers = lay(0, 1, 5, z);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step("t1");
      chk("t1.alt_rgb", int'(oRGB), (k % 2 == 0) ? 5 : 0);
      chk("t1.alt_strobe", int'(pix_strobe), (k % 2 == 0) ? 1 : 0);
    end

    // Vector table, full mask
    do_reset();
    for (int v = 0; v < 6; v++) begin
      visible = vecs[v].vis; in_layers = vecs[v].layers; bg_color = vecs[v].bg;
      for (int k = 0; k < DIV; k++) begin
        step("vec");
        if (k == 0) begin
          chk($sformatf("vec%0d.rgb", v), int'(oRGB), int'(vecs[v].exp_rgb));
          chk($sformatf("vec%0d.hit", v), int'(hit_any), int'(vecs[v].exp_hit));
          chk($sformatf("vec%0d.idx", v), int'(hit_idx), int'(vecs[v].exp_idx));
        end
      end
      $display("vec %0d: oRGB=%0d hit_any=%0d hit_idx=%0d", v, oRGB, hit_any, hit_idx);
    end

    // Test 2: mask 1101 removes layer 1
    visible = 1'b1; bg_color = 3'd7; in_layers = vecs[1].layers;
    slot("t2.pre", 3, 1, 1);
    cfg_valid = 1'b1; cfg_mask = 4'b1101; step("t2.offer"); cfg_valid = 1'b0;
    slot("t2.pend", 3, 1, 1);
    frame_start = 1'b1; step("t2.fs"); frame_start = 1'b0;
    slot("t2.post", 6, 1, 2);

    // Test 3: no opaque layer shows bg, invisible shows 0
    in_layers = z;
    slot("t3.bg", 7, 0, 0);
    visible = 1'b0; step("t3.invis"); step("t3.invis");
    chk("t3.invis_rgb", int'(oRGB), 0);
    visible = 1'b1;

    // Test 4: mask 0 mid-frame, second offer in PEND dropped
    in_layers = vecs[1].layers;
    cfg_valid = 1'b1; cfg_mask = 4'b0000; step("t4.offer");
    chk("t4.not_ready", int'(cfg_ready), 0);
    cfg_mask = 4'b1111; step("t4.drop"); cfg_valid = 1'b0;
    slot("t4.pend", 6, 1, 2);
    frame_start = 1'b1; step("t4.fs"); frame_start = 1'b0;
    chk("t4.ready", int'(cfg_ready), 1);
    slot("t4.post", 7, 0, 0);

    // Test 5: offer coincident with frame_start waits for the next one
    cfg_valid = 1'b1; frame_start = 1'b1; cfg_mask = 4'b1111; step("t5.both");
    cfg_valid = 1'b0; frame_start = 1'b0;
    slot("t5.held", 7, 0, 0);
    frame_start = 1'b1; step("t5.fs"); frame_start = 1'b0;
    slot("t5.applied", 3, 1, 1);
    cfg_valid = 1'b1; cfg_mask = 4'b0000; step("t5.offer2"); cfg_valid = 1'b0;
    do_reset();
    frame_start = 1'b1; step("t5.fs2"); frame_start = 1'b0;
    slot("t5.after_reset", 3, 1, 1);

`ifdef BLINK_EN
    // Blinking layer 0 over layer 1: two frames each phase
    do_reset();
    in_layers = lay(1, 1, 2, lay(0, 1, 5, z));
    cfg_valid = 1'b1; cfg_mask = 4'b1111; cfg_blink = 4'b0001; step("t6.offer");
    cfg_valid = 1'b0; cfg_blink = '0;
    frame_start = 1'b1; step("t6.apply"); frame_start = 1'b0;
    for (int f = 0; f < 8; f++) begin
      slot($sformatf("t6.f%0d", f), (m_blink_on) ? 5 : 2, 1, (m_blink_on) ? 0 : 1);
      frame_start = 1'b1; step("t6.fs"); frame_start = 1'b0;
    end
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      visible     = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      in_layers   = N*LW'($urandom);
      bg_color    = CW'($urandom);
      cfg_valid   = ($urandom_range(0, 9) == 0);
      cfg_mask    = N'($urandom);
      cfg_blink   = N'($urandom);
      if (n == 750) do_reset();
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
